// File: rtl/refill_arbiter.sv
// Refill arbiter: shares one AXI read channel between the icache and dcache
// refill ports, issuing one INCR line burst per grant and returning the line.
module refill_arbiter #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] I_ID       = 4'd0,
  parameter logic [3:0] D_ID       = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  input  logic        d_rd_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic [31:0] line_data [0:LINE_WORDS-1],
  output logic        refill_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [1:0]  o_state
);

  localparam int CW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFF = $clog2(LINE_WORDS) + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_win_d;   // 1: current burst belongs to the dcache
  logic            r_last_d;  // 1: dcache was served last
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic            w_pick_d;
  logic [31:0]     w_sel_addr;
  logic [31:0]     w_line_addr;
  logic            w_beat_err;
  logic            w_last_ok;
  logic            w_unused;

  // Handshakes: AR and R transfer on a rising edge where valid && ready;
  // AR fields hold steady while arvalid waits for arready.
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign o_state = r_state;

  always_comb begin
    w_pick_d    = d_rd_req && (!i_rd_req || !r_last_d);
    w_sel_addr  = w_pick_d ? d_addr : i_addr;
    w_line_addr = {w_sel_addr[31:OFF], {OFF{1'b0}}};
    w_beat_err  = (rid != arid) || (rresp != 2'b00);
    w_last_ok   = (r_cnt == CW'(LINE_WORDS - 1));
  end

  assign w_unused = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_win_d    <= 1'b0;
      r_last_d   <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arid       <= '0;
      rready     <= 1'b0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      refill_err <= 1'b0;
      for (int k = 0; k < LINE_WORDS; k++) line_data[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_rd_req || d_rd_req) begin
            r_win_d <= w_pick_d;
            araddr  <= w_line_addr;
            arid    <= w_pick_d ? D_ID : I_ID;
            arvalid <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rvalid) begin
            line_data[r_cnt] <= rdata;
            r_cnt            <= r_cnt + CW'(1);
            if (rlast) begin
              // A short or long burst is flagged but still completes the refill.
              rready     <= 1'b0;
              i_gnt      <= !r_win_d;
              d_gnt      <= r_win_d;
              refill_err <= r_err || w_beat_err || !w_last_ok;
              r_err      <= r_err || w_beat_err || !w_last_ok;
              r_state    <= S_DONE;
            end else begin
              r_err <= r_err || w_beat_err;
            end
          end
        end
        S_DONE: begin
          i_gnt      <= 1'b0;
          d_gnt      <= 1'b0;
          refill_err <= 1'b0;
          r_last_d   <= r_win_d;
          r_cnt      <= '0;
          r_err      <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// Bench for refill_arbiter: table of refill scenarios driven through a
// cycle-accurate AXI slave, with a queue of expected line words.
module tb_refill_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd_req, d_rd_req;
  logic [31:0] i_addr, d_addr;
  logic        i_gnt, d_gnt, refill_err;
  logic [31:0] line_data [0:LW-1];
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [1:0]  o_state;

  refill_arbiter #(.LINE_WORDS(LW), .I_ID(4'd0), .D_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .d_rd_req(d_rd_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .line_data(line_data), .refill_err(refill_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_line [0:LW-1];

  typedef struct {
    bit          set_i;
    bit          set_d;
    logic [31:0] ia;
    logic [31:0] da;
    int          ar_stall;
    bit          r_gap;
    int          err_beat;
    int          bad_id_beat;
    int          last_beat;
    bit          hold;
    bit          chk_lat;
    bit          exp_win_d;
    bit          exp_err;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(bit si, bit sd, logic [31:0] ia, logic [31:0] da,
                              int stall, bit gap, int eb, int bb, int lb,
                              bit hold, bit lat, bit wd, bit err);
    vec_t v;
    v.set_i = si; v.set_d = sd; v.ia = ia; v.da = da;
    v.ar_stall = stall; v.r_gap = gap; v.err_beat = eb; v.bad_id_beat = bb;
    v.last_beat = lb; v.hold = hold; v.chk_lat = lat;
    v.exp_win_d = wd; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    i_rd_req = 1'b0; d_rd_req = 1'b0; i_addr = '0; d_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; rresp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LW; k++) model_line[k] = '0;
    exp_q.delete();
  endtask

  task automatic wait_arvalid(output bit seen);
    seen = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (arvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("arvalid_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_refill(input vec_t v, input int idx);
    int          t0;
    int          j;
    bit          seen;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    logic [31:0] word;
    if (v.set_i) begin i_rd_req = 1'b1; i_addr = v.ia; end
    if (v.set_d) begin d_rd_req = 1'b1; d_addr = v.da; end
    t0       = cyc;
    exp_id   = v.exp_win_d ? 4'd1 : 4'd0;
    exp_addr = (v.exp_win_d ? d_addr : i_addr) & 32'hFFFF_FFE0;
    wait_arvalid(seen);
    if (!seen) return;
    if (v.chk_lat) chk("ar_latency", 32'(cyc - t0), 32'd1);
    chk("araddr", araddr, exp_addr);
    chk("arid", 32'(arid), 32'(exp_id));
    chk("arlen", 32'(arlen), 32'd7);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);
    for (int s = 0; s < v.ar_stall; s++) begin
      arready = 1'b0;
      @(negedge clk);
      chk("ar_hold_valid", 32'(arvalid), 32'd1);
      chk("ar_hold_addr", araddr, exp_addr);
      chk("ar_hold_id", 32'(arid), 32'(exp_id));
      chk("ar_hold_len", 32'(arlen), 32'd7);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int k = 0; k <= v.last_beat; k++) begin
      if (v.r_gap && k > 0) begin
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
      end
      chk("rready", 32'(rready), 32'd1);
      word   = (idx == 0) ? 32'h1000 + 32'(k) : {16'($urandom_range(0, 65535)), 16'(k)};
      rvalid = 1'b1;
      rdata  = word;
      rresp  = (k == v.err_beat) ? 2'b10 : 2'b00;
      rid    = (k == v.bad_id_beat) ? 4'hA : exp_id;
      rlast  = (k == v.last_beat);
      exp_q.push_back(word);
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (v.chk_lat) chk("gnt_latency", 32'(cyc - t0), 32'd10);
    chk("i_gnt", 32'(i_gnt), 32'(!v.exp_win_d));
    chk("d_gnt", 32'(d_gnt), 32'(v.exp_win_d));
    chk("refill_err", 32'(refill_err), 32'(v.exp_err));
    chk("rready_off", 32'(rready), 32'd0);
    // scoreboard: returned words land at consecutive line offsets
    j = 0;
    while (exp_q.size() > 0) begin
      word = exp_q.pop_front();
      model_line[j] = word;
      chk("line_word", line_data[j], word);
      j++;
    end
    if (!v.hold) begin
      if (v.exp_win_d) d_rd_req = 1'b0;
      else             i_rd_req = 1'b0;
    end
    @(negedge clk);
    chk("i_gnt_pulse", 32'(i_gnt), 32'd0);
    chk("d_gnt_pulse", 32'(d_gnt), 32'd0);
    chk("err_pulse", 32'(refill_err), 32'd0);
    chk("idle_after_done", 32'(o_state), 32'd0);
    for (int k = 0; k < LW; k++) chk("line_stable", line_data[k], model_line[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    //              si sd ia            da            stl gap eb  bb  lb hold lat wd err
    vecs[0]  = mk(1, 0, 32'hBFC0_0024, 32'h0,        0, 0, -1, -1, 7, 0, 1, 0, 0);
    vecs[1]  = mk(1, 1, 32'h0000_1040, 32'h8000_0004, 0, 0, -1, -1, 7, 0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 32'h0,         32'h8000_0104, 0, 0, -1, -1, 7, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 32'h0000_2060, 32'h0,        0, 0, -1, -1, 7, 0, 0, 1, 0);
    vecs[4]  = mk(0, 1, 32'h0,         32'h8000_0244, 0, 0, -1, -1, 7, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 32'h0000_30FC, 32'h0,        0, 0, -1, -1, 7, 0, 0, 1, 0);
    vecs[6]  = mk(0, 1, 32'h0,         32'h8000_031F, 0, 0, -1, -1, 7, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 32'h0,         32'h0,        5, 1, -1, -1, 7, 0, 0, 1, 0);
    vecs[8]  = mk(1, 0, 32'h1234_5678, 32'h0,        0, 0,  3, -1, 7, 0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 32'h0,         32'h0000_0FE0, 0, 0, -1, -1, 5, 0, 0, 1, 1);
    vecs[10] = mk(1, 0, 32'hABCD_EF00, 32'h0,        0, 0, -1, -1, 7, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 32'h0,         32'h7777_7788, 0, 0, -1,  2, 7, 0, 0, 1, 1);
    vecs[12] = mk(0, 1, 32'h0,         32'h4000_0010, 0, 0, -1, -1, 7, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 32'h0,         32'h0,        2, 1, -1, -1, 7, 0, 0, 1, 0);
    vecs[14] = mk(1, 1, 32'h0000_6000, 32'h9000_0040, 0, 0, -1, -1, 7, 0, 0, 1, 0);

    do_reset();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_err", 32'(refill_err), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd7);
    chk("rst_arsize", 32'(arsize), 32'd2);
    chk("rst_arburst", 32'(arburst), 32'd1);
    for (int k = 0; k < LW; k++) chk("rst_line", line_data[k], 32'd0);

    do_refill(vecs[0], 0);

    do_reset();
    for (int n = 1; n <= 13; n++) do_refill(vecs[n], n);

    // reset in the middle of the data phase
    i_rd_req = 1'b1;
    i_addr   = 32'h0000_5000;
    wait_arvalid(seen);
    if (seen) begin
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        rvalid = 1'b1; rdata = 32'hDEAD_0000 + 32'(k); rid = 4'd0; rresp = 2'b00; rlast = 1'b0;
        @(negedge clk);
      end
      rvalid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", 32'(o_state), 32'd0);
    chk("midrst_rready", 32'(rready), 32'd0);
    chk("midrst_arvalid", 32'(arvalid), 32'd0);
    chk("midrst_i_gnt", 32'(i_gnt), 32'd0);
    chk("midrst_d_gnt", 32'(d_gnt), 32'd0);
    chk("midrst_line0", line_data[0], 32'd0);
    rst = 1'b0;
    i_rd_req = 1'b0;
    for (int k = 0; k < LW; k++) model_line[k] = '0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_no_gnt_i", 32'(i_gnt), 32'd0);
    chk("midrst_no_gnt_d", 32'(d_gnt), 32'd0);
    do_refill(vecs[14], 14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
